// File: rtl/apb_bridge_nslv.sv
// rtl/apb_bridge_nslv.sv - valid/ready request to APB master for NSLV slaves with wait states and errors
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_bridge_nslv #(
   parameter int AW          = 16,
   parameter int DW          = 32,
   parameter int NSLV        = 3,
   parameter int REGION_BITS = 14,
   parameter int TIMEOUT     = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [AW-1:0]      req_addr,
   input  logic [DW-1:0]      req_wdata,
   output logic               rsp_valid,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic [NSLV-1:0]    psel,
   output logic               penable,
   output logic               pwrite,
   output logic [AW-1:0]      paddr,
   output logic [DW-1:0]      pwdata,
   input  logic [NSLV*DW-1:0] prdata,
   input  logic [NSLV-1:0]    pready,
   input  logic [NSLV-1:0]    pslverr
);

   localparam int IW = AW - REGION_BITS;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t            state;
   logic [IW-1:0]     req_idx;
   logic [NSLV-1:0]   dec_mask;
   logic              sel_ready;
   logic              sel_err;
   logic [DW-1:0]     sel_rdata;
   logic              to_hit;

   generate
      if (NSLV < 1 || NSLV > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
         $error("apb_bridge_nslv: parameter out of range");
      end
   endgenerate

   // Full-address decode: region indices at or above NSLV produce an empty mask.
   assign req_idx = req_addr[AW-1:REGION_BITS];

   always_comb begin
      dec_mask = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (32'(req_idx) == i) dec_mask[i] = 1'b1;
      end
   end

   // The registered psel doubles as the mask that picks the selected slave's response.
   assign sel_ready = |(pready & psel);
   assign sel_err   = |(pslverr & psel);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (psel[i]) sel_rdata = sel_rdata | prdata[i*DW +: DW];
      end
   end

`ifdef APB_TIMEOUT_EN
   logic [15:0] to_cnt;
   assign to_hit = (17'(to_cnt) + 17'd1) >= 17'(TIMEOUT);
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         psel      <= '0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  pwrite    <= req_write;
                  paddr     <= req_addr;
                  pwdata    <= req_wdata;
                  psel      <= dec_mask;
                  state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               // A decode miss spends its SETUP slot with no select, then reports the error.
               if (psel == '0) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= S_RESP;
               end else begin
                  penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                  to_cnt  <= '0;
`endif
                  state   <= S_ACCESS;
               end
            end
            S_ACCESS: begin
`ifdef APB_TIMEOUT_EN
               to_cnt <= to_cnt + 16'd1;
`endif
               if (sel_ready) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= sel_err;
                  rsp_rdata <= (!pwrite && !sel_err) ? sel_rdata : '0;
                  state     <= S_RESP;
               end else if (to_hit) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// tb/tb_apb_bridge_nslv.sv - directed self-checking bench for apb_bridge_nslv
// Slave model: selectable wait states / error / hang; unselected slaves drive pready=1, pslverr=1.
module tb_apb_bridge_nslv;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int NSLV = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic               req_valid;
   logic               req_ready;
   logic               req_write;
   logic [AW-1:0]      req_addr;
   logic [DW-1:0]      req_wdata;
   logic               rsp_valid;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_err;
   logic [NSLV-1:0]    psel;
   logic               penable;
   logic               pwrite;
   logic [AW-1:0]      paddr;
   logic [DW-1:0]      pwdata;
   logic [NSLV*DW-1:0] prdata;
   logic [NSLV-1:0]    pready;
   logic [NSLV-1:0]    pslverr;

   int n_cmp = 0;
   int n_bad = 0;
   int waits_cfg = 0;
   bit err_cfg = 1'b0;
   bit hang = 1'b0;
   int acc_cnt = 0;

   apb_bridge_nslv #(.AW(AW), .DW(DW), .NSLV(NSLV), .REGION_BITS(14), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   assign prdata = {32'hC2C2C2C2, 32'h12345678, 32'hA0A00000};

   always @(posedge clk) begin
      if (penable && |psel) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   always_comb begin
      for (int i = 0; i < NSLV; i++) begin
         pready[i]  = psel[i] ? (penable && !hang && acc_cnt >= waits_cfg) : 1'b1;
         pslverr[i] = psel[i] ? err_cfg : 1'b1;
      end
   end

   // Presents a request and returns #1 after the accepting edge (DUT then in SETUP).
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output bit ok, output int edges);
      req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
      ok = 1'b0; edges = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (req_ready) ok = 1'b1;
         @(posedge clk); #1;
         edges++;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit seen, output int lat, output int acc,
                           output logic [NSLV-1:0] psel_or, output logic [DW-1:0] rd, output bit er);
      seen = 1'b0; lat = 0; acc = 0; psel_or = psel; rd = '0; er = 1'b0;
      for (int i = 0; i < 150 && !seen; i++) begin
         if (penable) acc++;
         @(posedge clk); #1;
         lat++;
         psel_or |= psel;
         if (rsp_valid) begin
            seen = 1'b1; rd = rsp_rdata; er = rsp_err;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      n_cmp++; if (psel !== 3'b000) begin n_bad++; $display("FAIL reset_psel got %b exp 000", psel); end
      n_cmp++; if (penable !== 1'b0) begin n_bad++; $display("FAIL reset_penable got %b exp 0", penable); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      n_cmp++; if (paddr !== 16'h0000) begin n_bad++; $display("FAIL reset_paddr got %h exp 0000", paddr); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      bit ok; int e;
      waits_cfg = 0; err_cfg = 1'b0; hang = 1'b0;
      issue(1'b1, 16'h0010, 32'hDEADBEEF, ok, e);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_accept got %b exp 1", ok); end
      n_cmp++; if (psel !== 3'b001 || penable !== 1'b0) begin n_bad++; $display("FAIL wr_setup got psel=%b pen=%b exp 001/0", psel, penable); end
      n_cmp++; if (paddr !== 16'h0010 || pwrite !== 1'b1 || pwdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_bus got %h/%b/%h exp 0010/1/deadbeef", paddr, pwrite, pwdata); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL wr_busy_ready got %b exp 0", req_ready); end
      @(posedge clk); #1;
      n_cmp++; if (psel !== 3'b001 || penable !== 1'b1) begin n_bad++; $display("FAIL wr_access got psel=%b pen=%b exp 001/1", psel, penable); end
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rsp got v=%b e=%b d=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
      n_cmp++; if (psel !== 3'b000 || penable !== 1'b0) begin n_bad++; $display("FAIL wr_resp_bus got psel=%b pen=%b exp 000/0", psel, penable); end
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_idle got v=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
      n_cmp++; if (paddr !== 16'h0010) begin n_bad++; $display("FAIL wr_paddr_hold got %h exp 0010", paddr); end
   endtask

   task automatic test_read_wait();
      bit ok, seen, er; int e, lat, acc; logic [NSLV-1:0] po; logic [DW-1:0] rd;
      waits_cfg = 3;
      issue(1'b0, 16'h4004, 32'h0, ok, e);
      n_cmp++; if (psel !== 3'b010 || pwrite !== 1'b0) begin n_bad++; $display("FAIL rd_setup got psel=%b pw=%b exp 010/0", psel, pwrite); end
      wait_rsp(seen, lat, acc, po, rd, er);
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rd_seen got %b exp 1", seen); end
      n_cmp++; if (lat + 1 !== 6) begin n_bad++; $display("FAIL rd_latency got N+%0d exp N+6", lat + 1); end
      n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL rd_access_cycles got %0d exp 4", acc); end
      n_cmp++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_bad++; $display("FAIL rd_data got %h/%b exp 12345678/0", rd, er); end
      waits_cfg = 0;
   endtask

   task automatic test_decode_err();
      bit ok, seen, er; int e, lat, acc; logic [NSLV-1:0] po; logic [DW-1:0] rd;
      issue(1'b0, 16'hC000, 32'h0, ok, e);
      wait_rsp(seen, lat, acc, po, rd, er);
      n_cmp++; if (seen !== 1'b1 || lat + 1 !== 2) begin n_bad++; $display("FAIL dec_latency got seen=%b N+%0d exp 1 N+2", seen, lat + 1); end
      n_cmp++; if (po !== 3'b000 || acc !== 0) begin n_bad++; $display("FAIL dec_no_psel got psel=%b acc=%0d exp 000/0", po, acc); end
      n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL dec_rsp got e=%b d=%h exp 1/0", er, rd); end
   endtask

   task automatic test_back_to_back();
      bit ok, seen, er; int e, lat, acc; logic [NSLV-1:0] po; logic [DW-1:0] rd;
      err_cfg = 1'b1;
      issue(1'b1, 16'h8000, 32'h55AA55AA, ok, e);
      n_cmp++; if (psel !== 3'b100) begin n_bad++; $display("FAIL slverr_psel got %b exp 100", psel); end
      wait_rsp(seen, lat, acc, po, rd, er);
      n_cmp++; if (seen !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL slverr_rsp got v=%b e=%b d=%h exp 1/1/0", seen, er, rd); end
      err_cfg = 1'b0;
      issue(1'b0, 16'h0008, 32'h0, ok, e);
      n_cmp++; if (ok !== 1'b1 || e !== 2) begin n_bad++; $display("FAIL b2b_accept got ok=%b edges=%0d exp 1/2", ok, e); end
      wait_rsp(seen, lat, acc, po, rd, er);
      n_cmp++; if (seen !== 1'b1 || rd !== 32'hA0A00000 || er !== 1'b0) begin n_bad++; $display("FAIL b2b_rsp got v=%b d=%h e=%b exp 1/a0a00000/0", seen, rd, er); end
   endtask

   task automatic test_reset_mid();
      bit ok, pulse; int e;
      hang = 1'b1;
      issue(1'b0, 16'h4000, 32'h0, ok, e);
      @(posedge clk); #1;
      n_cmp++; if (penable !== 1'b1) begin n_bad++; $display("FAIL rst_mid_access got pen=%b exp 1", penable); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      pulse = rsp_valid;
      n_cmp++; if (psel !== 3'b000 || penable !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_bus got psel=%b pen=%b rdy=%b exp 000/0/1", psel, penable, req_ready); end
      reset = 1'b0; hang = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pulse |= rsp_valid;
      end
      n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_rsp got %b exp 0", pulse); end
   endtask

   task automatic test_timeout();
      bit ok, seen, er; int e, lat, acc; logic [NSLV-1:0] po; logic [DW-1:0] rd;
      hang = 1'b1;
      issue(1'b0, 16'h4010, 32'h0, ok, e);
      wait_rsp(seen, lat, acc, po, rd, er);
`ifdef APB_TIMEOUT_EN
      n_cmp++; if (seen !== 1'b1 || acc !== 4 || lat !== 5) begin n_bad++; $display("FAIL timeout_abort got v=%b acc=%0d lat=%0d exp 1/4/5", seen, acc, lat); end
      n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL timeout_rsp got e=%b d=%h exp 1/0", er, rd); end
`else
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL no_timeout_rsp got %b exp 0", seen); end
      n_cmp++; if (penable !== 1'b1 || psel !== 3'b010) begin n_bad++; $display("FAIL no_timeout_wait got pen=%b psel=%b exp 1/010", penable, psel); end
`endif
      hang = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_decode_err();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
